// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared pointer helpers for the dual-clock FIFO controllers
package async_fifo_pkg;

    // Default geometry; each controller may override ADDR_W per instance.
    localparam int ADDR_W_DEFAULT = 4;
    localparam int DEPTH          = 2**ADDR_W_DEFAULT;

    // Widest pointer the helpers handle. Narrower pointers are zero-extended in
    // and truncated out. Leading zeros do not change either conversion.
    localparam int PTR_MAX_W = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-side controller of the dual-clock FIFO
module async_fifo_wr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int AFULL_THRESH = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wvalid_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic              wready_o,
    input  logic [ADDR_W:0]   rptr_gray_sync_i,
    output logic [ADDR_W:0]   wptr_gray_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic [ADDR_W:0]   wlevel_o,
    output logic              overflow_o,
    input  logic              clr_overflow_i
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AFULL_T = PTR_W'(AFULL_THRESH);

    logic [PTR_W-1:0] wptr_bin;
    logic [PTR_W-1:0] wptr_bin_next;
    logic [PTR_W-1:0] gray_next;
    logic [PTR_W-1:0] rptr_bin;
    logic [PTR_W-1:0] level_next;
    logic             accept;
    logic             full_next;
    logic             afull_next;

    assign wready_o    = ~full_o & ~rst_i;
    assign accept      = wvalid_i & wready_o;
    assign mem_we_o    = accept;
    assign mem_waddr_o = wptr_bin[ADDR_W-1:0];
    assign mem_wdata_o = wdata_i;

    // Post-accept pointer and the flags it implies against the synchronized read pointer.
    // Full compares Gray codes directly: full when the top two bits differ and the rest match.
    always_comb begin
        wptr_bin_next = wptr_bin + {{ADDR_W{1'b0}}, accept};
        gray_next     = PTR_W'(bin2gray(PTR_MAX_W'(wptr_bin_next)));
        rptr_bin      = PTR_W'(gray2bin(PTR_MAX_W'(rptr_gray_sync_i)));
        level_next    = wptr_bin_next - rptr_bin;
        full_next     = (gray_next == {~rptr_gray_sync_i[ADDR_W:ADDR_W-1],
                                       rptr_gray_sync_i[ADDR_W-2:0]});
        afull_next    = (level_next >= AFULL_T);
    end

    // Pointer, status and sticky overflow registers; the Gray pointer leaves from a flop
    // so the far domain never sees a combinational glitch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_bin      <= '0;
            wptr_gray_o   <= '0;
            full_o        <= 1'b0;
            almost_full_o <= 1'b0;
            wlevel_o      <= '0;
            overflow_o    <= 1'b0;
        end else begin
            wptr_bin      <= wptr_bin_next;
            wptr_gray_o   <= gray_next;
            full_o        <= full_next;
            almost_full_o <= afull_next;
            wlevel_o      <= level_next;
            overflow_o    <= (wvalid_i & full_o) | (overflow_o & ~clr_overflow_i);
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - self-checking bench for async_fifo_wr_ctrl
module tb_async_fifo_wr_ctrl;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam int THRESH = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              wvalid_i;
    logic [WIDTH-1:0]  wdata_i;
    logic              wready_o;
    logic [ADDR_W:0]   rptr_gray_sync_i;
    logic [ADDR_W:0]   wptr_gray_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_waddr_o;
    logic [WIDTH-1:0]  mem_wdata_o;
    logic              full_o;
    logic              almost_full_o;
    logic [ADDR_W:0]   wlevel_o;
    logic              overflow_o;
    logic              clr_overflow_i;

    async_fifo_wr_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AFULL_THRESH(THRESH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wvalid_i(wvalid_i), .wdata_i(wdata_i),
        .wready_o(wready_o), .rptr_gray_sync_i(rptr_gray_sync_i), .wptr_gray_o(wptr_gray_o),
        .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
        .full_o(full_o), .almost_full_o(almost_full_o), .wlevel_o(wlevel_o),
        .overflow_o(overflow_o), .clr_overflow_i(clr_overflow_i)
    );

    always #5 clk_i = ~clk_i;

    // External RAM stand-in
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk_i) if (mem_we_o) ram[mem_waddr_o] <= mem_wdata_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: total words written, expected flags, sticky overflow, data queue
    int               m_wr;
    bit               m_full;
    bit               m_ov;
    logic [WIDTH-1:0] m_q [$];
    logic [ADDR_W:0]  prev_gray;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W:0] gray_of(input int n);
        logic [ADDR_W:0] b;
        b = (ADDR_W+1)'(n % (2*DEPTH));
        return b ^ (b >> 1);
    endfunction

    // One write-domain cycle; entered just after a negedge, returns just after the next one.
    // rd_vis is the number of reads the synchronized read pointer reports this cycle.
    task automatic tick(input bit wv, input logic [WIDTH-1:0] wd, input bit clr, input int rd_vis);
        bit acc;
        int lvl;
        rptr_gray_sync_i = gray_of(rd_vis);
        wvalid_i         = wv;
        wdata_i          = wd;
        clr_overflow_i   = clr;
        #1;
        acc = wv && !m_full;
        chk("mem_we", 32'(mem_we_o), 32'(acc));
        if (acc) begin
            chk("mem_waddr", 32'(mem_waddr_o), 32'(m_wr % DEPTH));
            chk("mem_wdata", mem_wdata_o, wd);
            m_q.push_back(wd);
            m_wr++;
        end
        m_ov   = (wv && m_full) || (m_ov && !clr);
        lvl    = m_wr - rd_vis;
        m_full = (lvl == DEPTH);
        @(negedge clk_i);
        chk("wptr_gray", 32'(wptr_gray_o), 32'(gray_of(m_wr)));
        chk("wlevel", 32'(wlevel_o), 32'(lvl));
        chk("full", 32'(full_o), 32'(m_full));
        chk("almost_full", 32'(almost_full_o), 32'(lvl >= THRESH));
        chk("wready", 32'(wready_o), 32'(!m_full));
        chk("overflow", 32'(overflow_o), 32'(m_ov));
        chk("gray_hamming_le1", 32'($countones(wptr_gray_o ^ prev_gray) <= 1), 32'd1);
        prev_gray = wptr_gray_o;
    endtask

    task automatic do_reset();
        rst_i            = 1'b1;
        wvalid_i         = 1'b1;
        wdata_i          = '0;
        clr_overflow_i   = 1'b0;
        rptr_gray_sync_i = '0;
        repeat (2) begin
            @(negedge clk_i);
            chk("rst_wready", 32'(wready_o), 32'd0);
            chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        end
        rst_i    = 1'b0;
        wvalid_i = 1'b0;
        #1;
        chk("rel_wready", 32'(wready_o), 32'd1);
        chk("rel_gray", 32'(wptr_gray_o), 32'd0);
        chk("rel_level", 32'(wlevel_o), 32'd0);
        chk("rel_flags", {29'd0, full_o, almost_full_o, overflow_o}, 32'd0);
        chk("rel_waddr", 32'(mem_waddr_o), 32'd0);
        m_wr = 0; m_full = 0; m_ov = 0; prev_gray = '0;
        m_q.delete();
    endtask

    initial begin
        logic [ADDR_W:0] gtab [4];
        int rd_cnt, rd_d1, rd_d2, wr_d1, wr_d2;
        logic [WIDTH-1:0] exp_w;
        gtab[0] = 3'd1; gtab[1] = 3'd3; gtab[2] = 3'd2; gtab[3] = 3'd6;

        // Reset
        rst_i = 1'b1;
        do_reset();

        // Fill
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, WIDTH'(32'hA0 + i), 1'b0, 0);
            chk("fill_gray", 32'(wptr_gray_o), 32'(gtab[i]));
            if (i == 2) chk("fill_afull3", 32'(almost_full_o), 32'd1);
        end
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_wready", 32'(wready_o), 32'd0);
        chk("fill_level", 32'(wlevel_o), 32'd4);

        // Overflow
        tick(1'b1, 32'hBB, 1'b0, 0);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        tick(1'b0, 32'h0, 1'b0, 0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        tick(1'b1, 32'hBC, 1'b1, 0);
        chk("ovf_set_wins", 32'(overflow_o), 32'd1);
        tick(1'b0, 32'h0, 1'b1, 0);
        chk("ovf_clear", 32'(overflow_o), 32'd0);

        // Drain and wrap
        tick(1'b0, 32'h0, 1'b0, 4);
        chk("drain_full", 32'(full_o), 32'd0);
        chk("drain_level", 32'(wlevel_o), 32'd0);
        for (int i = 0; i < DEPTH; i++) tick(1'b1, WIDTH'(32'hC0 + i), 1'b0, 4);
        chk("wrap_gray", 32'(wptr_gray_o), 32'd0);
        chk("wrap_full", 32'(full_o), 32'd1);

        // Reset mid-fill
        do_reset();
        tick(1'b1, 32'hD0, 1'b0, 0);
        tick(1'b1, 32'hD1, 1'b0, 0);
        chk("mid_level2", 32'(wlevel_o), 32'd2);
        do_reset();
        chk("mid_gray", 32'(wptr_gray_o), 32'd0);
        chk("mid_level", 32'(wlevel_o), 32'd0);
        chk("mid_addr", 32'(mem_waddr_o), 32'd0);
        tick(1'b1, 32'hD2, 1'b0, 0);

        // Random traffic with a modelled read side seeing the write pointer two cycles late
        do_reset();
        rd_cnt = 0; rd_d1 = 0; rd_d2 = 0; wr_d1 = 0; wr_d2 = 0;
        for (int c = 0; c < 10000; c++) begin
            if (rd_cnt < wr_d2 && $urandom_range(0, 2) != 0) begin
                if (m_q.size() == 0) begin
                    chk("model_queue_nonempty", 32'd0, 32'd1);
                end else begin
                    exp_w = m_q.pop_front();
                    chk("rd_data_order", ram[rd_cnt % DEPTH], exp_w);
                end
                rd_cnt++;
            end
            tick($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0, rd_d2);
            rd_d2 = rd_d1; rd_d1 = rd_cnt;
            wr_d2 = wr_d1; wr_d1 = m_wr;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
